// File: rtl/simple_pkg.sv
// Shared types and helpers for the multi-channel feedback cell.
// The feedback-mode encoding here matches the 2-bit mode port of simple_multi_ch.
package simple_pkg;

  typedef enum logic [1:0] {
    PULSE  = 2'b00,
    TOGGLE = 2'b01,
    STICKY = 2'b10,
    CLEAR  = 2'b11
  } mode_e;

  localparam int NCH_MIN   = 1;
  localparam int NCH_MAX   = 32;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;
  localparam int PC_W      = 6;

  // Counts set bits; callers zero-extend narrower channel vectors to NCH_MAX.
  function automatic logic [PC_W-1:0] popcount(input logic [NCH_MAX-1:0] v);
    logic [PC_W-1:0] n;
    n = {PC_W{1'b0}};
    for (int i = 0; i < NCH_MAX; i++) begin
      n = n + {{(PC_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/simple_pipe_stage.sv
// One valid/ready register stage. It loads whenever it is empty or its
// occupant is leaving, so no bubble is wasted.
module simple_pipe_stage
  import simple_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic         load_s;
  logic         vld_d, vld_q;
  logic [W-1:0] data_d, data_q;

  // Next-state: data only changes when a valid beat is captured.
  always_comb begin
    load_s = ~vld_q | out_rdy;
    vld_d  = vld_q;
    data_d = data_q;
    if (load_s) begin
      vld_d = in_vld;
      if (in_vld) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      vld_d  = vld_q;
      data_d = data_q;
    end
  end

  // Stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= {W{1'b0}};
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;

endmodule

// File: rtl/simple_multi_ch.sv
// Multi-channel NAND/NOR/DFF feedback cell: per-channel state bit q, selectable
// feedback mode, DEPTH-stage valid/ready output pipe and saturating rise counter.
module simple_multi_ch
  import simple_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic            iccad_clk,
  input  logic            iccad_rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [NCH-1:0]  inp1,
  input  logic [NCH-1:0]  inp2,
  input  logic [NCH-1:0]  en,
  input  logic [1:0]      mode,
  output logic [NCH-1:0]  out,
  output logic            out_vld,
  input  logic            out_rdy,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] evt_cnt
);

  if (NCH < NCH_MIN || NCH > NCH_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_param_err
    $error("simple_multi_ch: NCH or DEPTH out of range");
  end

  localparam int SUMW = CNTW + PC_W;

  mode_e                mode_s;
  logic                 acc_s;
  logic                 g_s, cand_s;
  logic [NCH-1:0]       qn_s;
  logic [NCH-1:0]       q_d, q_q;
  logic [NCH_MAX-1:0]   rise_s;
  logic [PC_W-1:0]      inc_s;
  logic [SUMW-1:0]      sum_s;
  logic [CNTW-1:0]      cnt_d, cnt_q;
  logic [DEPTH:0]       rdy_s;
  logic                 stg_vld_s  [DEPTH];
  logic [NCH-1:0]       stg_data_s [DEPTH];

  // Ready chain: a stage can take a beat if it is empty or its downstream can.
  always_comb begin
    rdy_s        = {(DEPTH+1){1'b0}};
    rdy_s[DEPTH] = out_rdy;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_s[i] = ~stg_vld_s[i] | rdy_s[i+1];
    end
  end

  assign in_rdy = rdy_s[0];
  assign acc_s  = in_vld & rdy_s[0];
  assign mode_s = mode_e'(mode);

  // Per-channel next state; PULSE is the NOR(NAND(a,b),q) loop.
  always_comb begin
    qn_s   = q_q;
    g_s    = 1'b0;
    cand_s = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      g_s = inp1[c] & inp2[c];
      case (mode_s)
        PULSE:   cand_s = g_s & ~q_q[c];
        TOGGLE:  cand_s = q_q[c] ^ g_s;
        STICKY:  cand_s = q_q[c] | g_s;
        CLEAR:   cand_s = 1'b0;
        default: cand_s = q_q[c];
      endcase
      if (mode_s == CLEAR) begin
        qn_s[c] = 1'b0;
      end else if (en[c]) begin
        qn_s[c] = cand_s;
      end else begin
        qn_s[c] = q_q[c];
      end
    end
  end

  // State and counter next values; clear beats any same-cycle increment.
  always_comb begin
    rise_s            = {NCH_MAX{1'b0}};
    rise_s[NCH-1:0]   = qn_s & ~q_q;
    inc_s             = popcount(rise_s);
    sum_s             = {{PC_W{1'b0}}, cnt_q} + {{CNTW{1'b0}}, inc_s};
    if (acc_s) begin
      q_d = qn_s;
    end else begin
      q_d = q_q;
    end
    if (cnt_clr) begin
      cnt_d = {CNTW{1'b0}};
    end else if (acc_s) begin
      if (sum_s > {{PC_W{1'b0}}, {CNTW{1'b1}}}) begin
        cnt_d = {CNTW{1'b1}};
      end else begin
        cnt_d = sum_s[CNTW-1:0];
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state and event counter registers.
  always_ff @(posedge iccad_clk or posedge iccad_rst) begin
    if (iccad_rst) begin
      q_q   <= {NCH{1'b0}};
      cnt_q <= {CNTW{1'b0}};
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      simple_pipe_stage #(.W(NCH)) u_stage (
        .clk      (iccad_clk),
        .rst      (iccad_rst),
        .in_vld   (acc_s),
        .in_data  (qn_s),
        .out_rdy  (rdy_s[i+1]),
        .out_vld  (stg_vld_s[i]),
        .out_data (stg_data_s[i])
      );
    end else begin : g_next
      simple_pipe_stage #(.W(NCH)) u_stage (
        .clk      (iccad_clk),
        .rst      (iccad_rst),
        .in_vld   (stg_vld_s[i-1]),
        .in_data  (stg_data_s[i-1]),
        .out_rdy  (rdy_s[i+1]),
        .out_vld  (stg_vld_s[i]),
        .out_data (stg_data_s[i])
      );
    end
  end

  assign out     = stg_data_s[DEPTH-1];
  assign out_vld = stg_vld_s[DEPTH-1];
  assign evt_cnt = cnt_q;

endmodule

// File: tb/tb_simple_multi_ch.sv
// Directed and random checks of simple_multi_ch against a slot/queue reference model.
module tb_simple_multi_ch;

  localparam int NCH   = 4;
  localparam int DEPTH = 2;
  localparam int CNTW  = 8;
  localparam int CMAX  = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vld, in_rdy, out_vld, out_rdy, cnt_clr;
  logic [NCH-1:0]  inp1, inp2, en, out;
  logic [1:0]      mode;
  logic [CNTW-1:0] evt_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [NCH-1:0] m_q;
  int             m_cnt;
  bit             m_v [DEPTH];
  logic [NCH-1:0] m_d [DEPTH];
  int             saved;

  always #5 clk = ~clk;

  simple_multi_ch #(.NCH(NCH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .iccad_clk (clk),
    .iccad_rst (rst),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .inp1      (inp1),
    .inp2      (inp2),
    .en        (en),
    .mode      (mode),
    .out       (out),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .cnt_clr   (cnt_clr),
    .evt_cnt   (evt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q   = '0;
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
  endtask

  // One cycle: called at a negedge, returns at the next negedge.
  task automatic step(input logic v, input logic [NCH-1:0] a, input logic [NCH-1:0] b,
                      input logic [NCH-1:0] e, input logic [1:0] m, input logic ordy,
                      input logic clr, input string tag);
    int             held;
    bit             mrdy, acc;
    logic [NCH-1:0] qn;
    bit             g, t;
    int             rises;
    in_vld = v; inp1 = a; inp2 = b; en = e; mode = m; out_rdy = ordy; cnt_clr = clr;
    #1;
    held = 0;
    for (int i = 0; i < DEPTH; i++) held += int'(m_v[i]);
    mrdy = ordy || (held < DEPTH);
    check({tag, "_in_rdy"}, 32'(in_rdy), 32'(mrdy));
    acc = v && mrdy;
    rises = 0;
    for (int c = 0; c < NCH; c++) begin
      g = a[c] && b[c];
      case (m)
        2'd0:    t = g && !m_q[c];
        2'd1:    t = m_q[c] != g;
        2'd2:    t = m_q[c] || g;
        default: t = 1'b0;
      endcase
      if (m != 2'd3 && !e[c]) t = m_q[c];
      qn[c] = t;
      if (t && !m_q[c]) rises++;
    end
    @(posedge clk);
    if (m_v[DEPTH-1] && ordy) m_v[DEPTH-1] = 1'b0;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      if (m_v[i] && !m_v[i+1]) begin
        m_v[i+1] = 1'b1;
        m_d[i+1] = m_d[i];
        m_v[i]   = 1'b0;
      end
    end
    if (acc) begin
      m_v[0] = 1'b1;
      m_d[0] = qn;
      m_q    = qn;
    end
    if (clr) m_cnt = 0;
    else if (acc) m_cnt = (m_cnt + rises > CMAX) ? CMAX : m_cnt + rises;
    @(negedge clk);
    check({tag, "_out_vld"}, 32'(out_vld), 32'(m_v[DEPTH-1]));
    if (m_v[DEPTH-1]) check({tag, "_out"}, 32'(out), 32'(m_d[DEPTH-1]));
    check({tag, "_evt_cnt"}, 32'(evt_cnt), 32'(m_cnt));
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; inp1 = '0; inp2 = '0; en = '0; mode = 2'd0;
    out_rdy = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out",     32'(out),     32'd0);
    check("rst_evt",     32'(evt_cnt), 32'd0);
    check("rst_in_rdy",  32'(in_rdy),  32'd1);
    rst = 1'b0;

    // 1: pulse mode, three beats -> F,0,F and 8 rises
    repeat (3) step(1'b1, 4'hF, 4'hF, 4'hF, 2'd0, 1'b1, 1'b0, "t1");
    check("t1_evt_lit", 32'(evt_cnt), 32'd8);
    repeat (2) step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b1, 1'b0, "t1_drain");

    // 2: clear, then toggle with en=5
    step(1'b1, 4'h0, 4'h0, 4'h0, 2'd3, 1'b1, 1'b0, "t2_clr");
    repeat (2) step(1'b1, 4'hF, 4'hF, 4'h5, 2'd1, 1'b1, 1'b0, "t2");
    check("t2_evt_lit", 32'(evt_cnt), 32'd10);
    repeat (2) step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b1, 1'b0, "t2_drain");

    // 3: back-pressure fills the pipe, third beat enters on the first drain
    step(1'b1, 4'hF, 4'hF, 4'hF, 2'd2, 1'b0, 1'b0, "t3_a");
    step(1'b1, 4'h3, 4'h3, 4'hF, 2'd0, 1'b0, 1'b0, "t3_b");
    step(1'b1, 4'hF, 4'hF, 4'hF, 2'd1, 1'b0, 1'b0, "t3_stall");
    check("t3_full_lit", 32'(in_rdy), 32'd0);
    step(1'b1, 4'hF, 4'hF, 4'hF, 2'd1, 1'b1, 1'b0, "t3_c");
    repeat (3) step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b1, 1'b0, "t3_drain");

    // 4: saturation then clear beating an increment
    for (int k = 0; k < 75; k++) begin
      step(1'b1, 4'hF, 4'hF, 4'hF, 2'd2, 1'b1, 1'b0, "t4_set");
      step(1'b1, 4'h0, 4'h0, 4'h0, 2'd3, 1'b1, 1'b0, "t4_clr");
    end
    check("t4_sat_lit", 32'(evt_cnt), 32'd255);
    step(1'b1, 4'hF, 4'hF, 4'hF, 2'd2, 1'b1, 1'b0, "t4_hold");
    check("t4_hold_lit", 32'(evt_cnt), 32'd255);
    step(1'b1, 4'h0, 4'h0, 4'h0, 2'd3, 1'b1, 1'b0, "t4_q0");
    step(1'b1, 4'hF, 4'hF, 4'hF, 2'd2, 1'b1, 1'b1, "t4_cclr");
    check("t4_cclr_lit", 32'(evt_cnt), 32'd0);

    // 5: clear mode ignores en=0 and leaves the count alone
    saved = int'(evt_cnt);
    step(1'b1, 4'h0, 4'h0, 4'h0, 2'd3, 1'b1, 1'b0, "t5");
    step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b1, 1'b0, "t5_drain");
    check("t5_out_lit", 32'(out), 32'd0);
    check("t5_evt_lit", 32'(evt_cnt), 32'(saved));

    // 6: asynchronous reset with two beats in flight
    step(1'b1, 4'hF, 4'hF, 4'hF, 2'd0, 1'b0, 1'b0, "t6_a");
    step(1'b1, 4'hF, 4'hF, 4'hF, 2'd1, 1'b0, 1'b0, "t6_b");
    #2 rst = 1'b1;
    #1;
    check("t6_out_vld", 32'(out_vld), 32'd0);
    check("t6_out",     32'(out),     32'd0);
    check("t6_evt",     32'(evt_cnt), 32'd0);
    check("t6_in_rdy",  32'(in_rdy),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 4'hF, 4'hF, 4'hF, 2'd0, 1'b1, 1'b0, "t6_post");
    step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b1, 1'b0, "t6_post2");
    check("t6_post_lit", 32'(out), 32'hF);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
           2'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
